// File: rtl/cache_pkg.sv
// cache_pkg: shared word width, refill FSM encoding and saturating increment
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam int MAX_CNT_WIDTH = 32;
    function automatic logic [MAX_CNT_WIDTH-1:0] sat_inc(input logic [MAX_CNT_WIDTH-1:0] v, input logic [MAX_CNT_WIDTH-1:0] max);
        return (v == max) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter
    import cache_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);
    localparam logic [MAX_CNT_WIDTH-1:0] MAX = MAX_CNT_WIDTH'({CNT_WIDTH{1'b1}});
    logic [CNT_WIDTH-1:0] r_count;
    assign o_count = r_count;
    // count one event per cycle, holding once the maximum is reached
    always_ff @(posedge clk or posedge rst)
        if (rst) r_count <= '0;
        else if (i_inc) r_count <= CNT_WIDTH'(sat_inc(MAX_CNT_WIDTH'(r_count), MAX));
endmodule

// File: rtl/cache_refill_controller.sv
// cache_refill_controller: serves hits from the cache, refills a whole block from RAM on a miss
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif
module cache_refill_controller
    import cache_pkg::*;
#(
    parameter int WORD_LENGTH = `WORD_LENGTH,
    parameter int ADDR_WIDTH  = 15,
    parameter int BLOCK_WORDS = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic [ADDR_WIDTH-1:0]  address,
    input  logic                   hit,
    input  logic [WORD_LENGTH-1:0] cache_out,
    input  logic [WORD_LENGTH-1:0] ram_rdata,
    input  logic                   ram_ready,
    output logic                   ram_read,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic                   cache_write,
    output logic [WORD_LENGTH-1:0] cache_wdata,
    output logic [ADDR_WIDTH-1:0]  cache_waddr,
    output logic [WORD_LENGTH-1:0] mem_out,
    output logic                   mem_valid,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   hit_count,
    output logic [CNT_WIDTH-1:0]   miss_count
);
    localparam int OFF = $clog2(BLOCK_WORDS);
    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [OFF-1:0]         r_beat;
    logic [WORD_LENGTH-1:0] r_word;
    logic [WORD_LENGTH-1:0] r_mem_out;
    logic                   r_mem_valid;
    logic                   w_fill;
    logic                   w_accept;
    assign w_fill      = r_state == FILL;
    assign w_accept    = r_state == IDLE && req;
    assign busy        = r_state != IDLE;
    assign ram_read    = w_fill;
    assign ram_addr    = w_fill ? {r_addr[ADDR_WIDTH-1:OFF], r_beat} : '0;
    assign cache_write = w_fill && ram_ready;
    assign cache_wdata = cache_write ? ram_rdata : '0;
    assign cache_waddr = cache_write ? ram_addr : '0;
    assign mem_out     = r_mem_out;
    assign mem_valid   = r_mem_valid;
    // accept requests in IDLE, walk the block beat by beat in FILL, return the captured word from DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_beat      <= '0;
            r_word      <= '0;
            r_mem_out   <= '0;
            r_mem_valid <= 1'b0;
        end else begin
            r_mem_valid <= 1'b0;
            case (r_state)
                IDLE: if (req) begin
                    r_addr <= address;
                    if (hit) begin
                        r_mem_out   <= cache_out;
                        r_mem_valid <= 1'b1;
                    end else begin
                        r_state <= FILL;
                        r_beat  <= '0;
                    end
                end
                FILL: if (ram_ready) begin
                    r_beat <= r_beat + 1'b1;
                    if (r_beat == r_addr[OFF-1:0]) r_word <= ram_rdata;
                    if (&r_beat) r_state <= DONE;
                end
                DONE: begin
                    r_mem_out   <= r_word;
                    r_mem_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
        .clk(clk), .rst(rst), .i_inc(w_accept && hit), .o_count(hit_count)
    );
    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk(clk), .rst(rst), .i_inc(w_accept && !hit), .o_count(miss_count)
    );
endmodule
